// File: rtl/keccak_ctrl_pkg.sv
// Shared types and constants for the Keccak sponge sequencer.
//   state_t      : sequencer FSM states
//   STATE_WORDS  : Keccak-f[1600] state size in 32-bit words
//   DS_SHA3/DS_SHAKE : domain-separation bytes
//   PAD_END_WORD : final padding bit in the last rate word
//   pad_word()   : masks a partial final beat and inserts the ds byte
package keccak_ctrl_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_CLEAR,
        S_ABSORB,
        S_PAD_DS,
        S_PAD_END,
        S_PERM,
        S_SQ_RD,
        S_SQ_OUT,
        S_DONE
    } state_t;

    localparam int unsigned STATE_WORDS  = 50;
    localparam logic [7:0]  DS_SHA3      = 8'h06;
    localparam logic [7:0]  DS_SHAKE     = 8'h1F;
    localparam logic [31:0] PAD_END_WORD = 32'h8000_0000;

    // Bytes below 'bytes' pass through, byte 'bytes' becomes ds, the rest are zero.
    function automatic logic [31:0] pad_word(input logic [31:0] data,
                                             input logic [2:0]  bytes,
                                             input logic [7:0]  ds);
        logic [31:0] w;
        w = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (i < 32'(bytes))
                w[8*i +: 8] = data[8*i +: 8];
            else if (i == 32'(bytes))
                w[8*i +: 8] = ds;
        end
        return w;
    endfunction

endpackage

// File: rtl/keccak_sponge_ctrl.sv
// Sponge-mode sequencer for a Keccak-f[1600] permutation core.
// Absorbs a 32-bit message stream into the rate, applies multi-rate padding,
// runs permutations and squeezes cfg_out_words digest words.
//   clk_i, rst_i                    : clock, synchronous active-high reset
//   start_i, cfg_*                  : start request and per-hash configuration
//   in_valid_i/in_ready_o/in_data_i/in_last_i/in_bytes_i : message stream
//   st_clr_o/st_addr_o/st_xor_o/st_wdata_o/st_re_o/st_rdata_i : core state port
//   perm_start_o/perm_done_i        : permutation handshake
//   out_valid_o/out_ready_i/out_data_o/out_last_o : digest stream
//   busy_o, done_o                  : status, completion pulse
module keccak_sponge_ctrl
    import keccak_ctrl_pkg::*;
#(
    parameter int unsigned MAX_RATE_WORDS = 42,
    parameter int unsigned OUT_CNT_W      = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic [5:0]           cfg_rate_words_i,
    input  logic [7:0]           cfg_dsbyte_i,
    input  logic [OUT_CNT_W-1:0] cfg_out_words_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [31:0]          in_data_i,
    input  logic                 in_last_i,
    input  logic [2:0]           in_bytes_i,
    output logic                 st_clr_o,
    output logic [5:0]           st_addr_o,
    output logic                 st_xor_o,
    output logic [31:0]          st_wdata_o,
    output logic                 st_re_o,
    input  logic [31:0]          st_rdata_i,
    output logic                 perm_start_o,
    input  logic                 perm_done_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [31:0]          out_data_o,
    output logic                 out_last_o,
    output logic                 busy_o,
    output logic                 done_o
);

    state_t               state;
    state_t               ret;          // where to resume after a permutation
    logic [5:0]           rate;
    logic [7:0]           ds;
    logic [OUT_CNT_W-1:0] out_words;
    logic [5:0]           wcnt;
    logic [5:0]           rcnt;
    logic [OUT_CNT_W-1:0] ocnt;
    logic                 perm_issued;
    logic                 fresh;        // first SQ_OUT cycle: read data is on st_rdata_i
    logic [31:0]          data_q;

    logic [5:0]           rate_clamped;
    logic                 partial;
    logic [31:0]          padded;
    logic [5:0]           wcnt_nxt;
    logic [5:0]           rcnt_nxt;
    logic [OUT_CNT_W-1:0] ocnt_nxt;

    always_comb begin
        rate_clamped = cfg_rate_words_i;
        if (cfg_rate_words_i == '0 || 32'(cfg_rate_words_i) > MAX_RATE_WORDS)
            rate_clamped = 6'(MAX_RATE_WORDS);
        partial  = in_last_i && (in_bytes_i < 3'd4);
        padded   = pad_word(in_data_i, in_bytes_i, ds);
        wcnt_nxt = wcnt + 6'd1;
        rcnt_nxt = rcnt + 6'd1;
        ocnt_nxt = ocnt + OUT_CNT_W'(1);
    end

    // The first digest word of each read is bypassed straight from the core so
    // a word leaves every two cycles; afterwards the captured copy is held.
    assign out_data_o = fresh ? st_rdata_i : data_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state        <= S_IDLE;
            ret          <= S_IDLE;
            rate         <= '0;
            ds           <= '0;
            out_words    <= '0;
            wcnt         <= '0;
            rcnt         <= '0;
            ocnt         <= '0;
            perm_issued  <= 1'b0;
            fresh        <= 1'b0;
            data_q       <= '0;
            in_ready_o   <= 1'b0;
            st_clr_o     <= 1'b0;
            st_addr_o    <= '0;
            st_xor_o     <= 1'b0;
            st_wdata_o   <= '0;
            st_re_o      <= 1'b0;
            perm_start_o <= 1'b0;
            out_valid_o  <= 1'b0;
            out_last_o   <= 1'b0;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
        end else begin
            st_clr_o     <= 1'b0;
            st_xor_o     <= 1'b0;
            st_re_o      <= 1'b0;
            perm_start_o <= 1'b0;
            done_o       <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (start_i) begin
                        rate      <= rate_clamped;
                        ds        <= cfg_dsbyte_i;
                        out_words <= cfg_out_words_i;
                        wcnt      <= '0;
                        rcnt      <= '0;
                        ocnt      <= '0;
                        st_clr_o  <= 1'b1;
                        busy_o    <= 1'b1;
                        state     <= S_CLEAR;
                    end
                end

                S_CLEAR: begin
                    in_ready_o <= 1'b1;
                    state      <= S_ABSORB;
                end

                S_ABSORB: begin
                    if (in_valid_i && in_ready_o) begin
                        st_xor_o   <= 1'b1;
                        st_addr_o  <= wcnt;
                        st_wdata_o <= partial ? padded : in_data_i;
                        // A partial last beat already carries the ds byte, so the
                        // end bit goes into the same block even if it just filled.
                        if (partial) begin
                            in_ready_o <= 1'b0;
                            state      <= S_PAD_END;
                        end else if (wcnt_nxt == rate) begin
                            in_ready_o <= 1'b0;
                            wcnt       <= '0;
                            ret        <= in_last_i ? S_PAD_DS : S_ABSORB;
                            state      <= S_PERM;
                        end else begin
                            wcnt <= wcnt_nxt;
                            if (in_last_i) begin
                                in_ready_o <= 1'b0;
                                state      <= S_PAD_DS;
                            end
                        end
                    end
                end

                S_PAD_DS: begin
                    st_xor_o   <= 1'b1;
                    st_addr_o  <= wcnt;
                    st_wdata_o <= {24'h0, ds};
                    state      <= S_PAD_END;
                end

                S_PAD_END: begin
                    st_xor_o   <= 1'b1;
                    st_addr_o  <= rate - 6'd1;
                    st_wdata_o <= PAD_END_WORD;
                    ret        <= S_SQ_RD;
                    state      <= S_PERM;
                end

                // Start is issued one cycle into PERM so the preceding XOR has
                // landed before the core begins.
                S_PERM: begin
                    if (!perm_issued) begin
                        perm_start_o <= 1'b1;
                        perm_issued  <= 1'b1;
                    end else if (perm_done_i && !perm_start_o) begin
                        perm_issued <= 1'b0;
                        case (ret)
                            S_ABSORB: begin
                                in_ready_o <= 1'b1;
                                state      <= S_ABSORB;
                            end
                            S_PAD_DS: state <= S_PAD_DS;
                            default: begin
                                if (out_words == '0) begin
                                    done_o <= 1'b1;
                                    state  <= S_DONE;
                                end else begin
                                    st_re_o   <= 1'b1;
                                    st_addr_o <= rcnt;
                                    state     <= S_SQ_RD;
                                end
                            end
                        endcase
                    end
                end

                S_SQ_RD: begin
                    out_valid_o <= 1'b1;
                    out_last_o  <= (ocnt_nxt == out_words);
                    fresh       <= 1'b1;
                    state       <= S_SQ_OUT;
                end

                S_SQ_OUT: begin
                    if (fresh) begin
                        data_q <= st_rdata_i;
                        fresh  <= 1'b0;
                    end
                    if (out_ready_i) begin
                        out_valid_o <= 1'b0;
                        out_last_o  <= 1'b0;
                        ocnt        <= ocnt_nxt;
                        if (out_last_o) begin
                            done_o <= 1'b1;
                            state  <= S_DONE;
                        end else if (rcnt_nxt == rate) begin
                            rcnt  <= '0;
                            ret   <= S_SQ_RD;
                            state <= S_PERM;
                        end else begin
                            rcnt      <= rcnt_nxt;
                            st_re_o   <= 1'b1;
                            st_addr_o <= rcnt_nxt;
                            state     <= S_SQ_RD;
                        end
                    end
                end

                S_DONE: begin
                    busy_o <= 1'b0;
                    state  <= S_IDLE;
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_keccak_sponge_ctrl.sv
// Directed bench for keccak_sponge_ctrl with a behavioural state/permutation
// core. The stand-in permutation XORs word i with {perm_number, 16'h0, i}.
module tb_keccak_sponge_ctrl;
    import keccak_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [5:0]  cfg_rate = '0;
    logic [7:0]  cfg_ds = '0;
    logic [7:0]  cfg_out = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic        in_last = 1'b0;
    logic [2:0]  in_bytes = '0;
    logic        st_clr, st_xor, st_re;
    logic [5:0]  st_addr;
    logic [31:0] st_wdata;
    logic [31:0] st_rdata = '0;
    logic        perm_start;
    logic        perm_done = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_data;
    logic        out_last;
    logic        busy, done;

    keccak_sponge_ctrl #(.MAX_RATE_WORDS(42), .OUT_CNT_W(8)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start),
        .cfg_rate_words_i(cfg_rate), .cfg_dsbyte_i(cfg_ds), .cfg_out_words_i(cfg_out),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data),
        .in_last_i(in_last), .in_bytes_i(in_bytes),
        .st_clr_o(st_clr), .st_addr_o(st_addr), .st_xor_o(st_xor), .st_wdata_o(st_wdata),
        .st_re_o(st_re), .st_rdata_i(st_rdata),
        .perm_start_o(perm_start), .perm_done_i(perm_done),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
        .out_last_o(out_last), .busy_o(busy), .done_o(done)
    );

    always #5 clk = ~clk;

    // Behavioural core: state memory, 1-cycle read latency, permutation 3 cycles after start.
    logic [31:0] mem [0:49];
    int unsigned pcount = 0;
    logic [7:0]  pnum = '0;

    always @(posedge clk) begin
        perm_done <= 1'b0;
        if (st_clr) begin
            for (int i = 0; i < 50; i++) mem[i] <= '0;
            pnum <= '0;
        end else if (st_xor) begin
            mem[st_addr] <= mem[st_addr] ^ st_wdata;
        end
        if (st_re) st_rdata <= mem[st_addr];
        if (perm_start) begin
            pcount <= 3;
        end else if (pcount != 0) begin
            pcount <= pcount - 1;
            if (pcount == 1) begin
                for (int i = 0; i < 50; i++) mem[i] <= mem[i] ^ {pnum + 8'd1, 16'h0, 8'(i)};
                pnum      <= pnum + 8'd1;
                perm_done <= 1'b1;
            end
        end
    end

    // Event logs, sampled on the falling edge.
    logic [31:0] xa[$], xd[$], ra[$], od[$], ol[$];
    int unsigned nclr = 0, nperm = 0, ncore_done = 0, ndone = 0, nexcl = 0;

    always @(negedge clk) begin
        if (st_xor) begin xa.push_back(32'(st_addr)); xd.push_back(st_wdata); end
        if (st_re) ra.push_back(32'(st_addr));
        if (st_clr) nclr++;
        if (perm_start) nperm++;
        if (perm_done) ncore_done++;
        if (done) ndone++;
        if (out_valid && out_ready) begin od.push_back(out_data); ol.push_back(32'(out_last)); end
        if (32'(st_xor) + 32'(st_re) + 32'(st_clr) > 1) nexcl++;
    end

    int unsigned checks = 0, passes = 0, fails = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] at(input logic [31:0] q[$], input int unsigned i);
        if (i < q.size()) return q[i];
        return 'x;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        xa.delete(); xd.delete(); ra.delete(); od.delete(); ol.delete();
        nclr = 0; nperm = 0; ncore_done = 0; ndone = 0;
    endtask

    task automatic start_hash(input logic [5:0] r, input logic [7:0] d, input logic [7:0] n);
        clear_logs();
        cfg_rate = r; cfg_ds = d; cfg_out = n;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_beat(input logic [31:0] d, input logic l, input logic [2:0] b);
        logic ok;
        ok = 1'b0;
        in_valid = 1'b1; in_data = d; in_last = l; in_bytes = b;
        for (int k = 0; k < 200; k++) begin
            if (in_ready) begin
                tick();
                ok = 1'b1;
                break;
            end
            tick();
        end
        in_valid = 1'b0; in_last = 1'b0;
        check("beat_accepted", 32'(ok), 32'd1);
    endtask

    task automatic wait_done(input string tag);
        for (int k = 0; k < 1000; k++) begin
            tick();
            if (ndone != 0) break;
        end
        tick();
        check(tag, ndone, 32'd1);
    endtask

    task automatic check_xor(input string tag, input int unsigned i,
                             input logic [31:0] a, input logic [31:0] d);
        check({tag, "_addr"}, at(xa, i), a);
        check({tag, "_data"}, at(xd, i), d);
    endtask

    function automatic logic [31:0] t1_word(input int unsigned i);
        return (i == 0) ? 32'h0100_0006 : (32'h0100_0000 + 32'(i));
    endfunction

    task automatic check_t1(input string tag);
        check({tag, "_xor_count"}, xa.size(), 32'd2);
        check_xor({tag, "_xor0"}, 0, 32'd0, 32'h0000_0006);
        check_xor({tag, "_xor1"}, 1, 32'd33, 32'h8000_0000);
        check({tag, "_perms"}, nperm, 32'd1);
        check({tag, "_clr"}, nclr, 32'd1);
        check({tag, "_reads"}, ra.size(), 32'd8);
        check({tag, "_words"}, od.size(), 32'd8);
        for (int unsigned i = 0; i < 8; i++) begin
            check({tag, "_raddr"}, at(ra, i), 32'(i));
            check({tag, "_word"}, at(od, i), t1_word(i));
            check({tag, "_last"}, at(ol, i), (i == 7) ? 32'd1 : 32'd0);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset
        repeat (3) tick();
        check("rst_ctrl", {23'h0, st_clr, st_xor, st_re, perm_start, out_valid, out_last,
                           busy, done, in_ready}, 32'h0);
        check("rst_addr", 32'(st_addr), 32'h0);
        check("rst_wdata", st_wdata, 32'h0);
        check("rst_odata", out_data, 32'h0);
        rst = 1'b0;
        tick();
        check("idle_busy", 32'(busy), 32'd0);

        // T1: empty SHA3-256
        start_hash(6'd34, DS_SHA3, 8'd8);
        check("t1_busy", 32'(busy), 32'd1);
        send_beat(32'hDEAD_BEEF, 1'b1, 3'd0);
        wait_done("t1_done");
        check_t1("t1");
        check("t1_idle", 32'(busy), 32'd0);

        // T2: partial beat; a start while busy must be ignored
        start_hash(6'd34, DS_SHA3, 8'd1);
        cfg_rate = 6'd5; cfg_out = 8'd3;
        tick(); tick();
        start = 1'b1;
        send_beat(32'h4433_2211, 1'b1, 3'd3);
        start = 1'b0;
        wait_done("t2_done");
        check("t2_xor_count", xa.size(), 32'd2);
        check_xor("t2_xor0", 0, 32'd0, 32'h0633_2211);
        check_xor("t2_xor1", 1, 32'd33, 32'h8000_0000);
        check("t2_words", od.size(), 32'd1);
        check("t2_word0", at(od, 0), 32'h0733_2211);
        check("t2_last0", at(ol, 0), 32'd1);
        check("t2_clr", nclr, 32'd1);

        // T3: exactly one full block of message
        start_hash(6'd34, DS_SHA3, 8'd2);
        for (int i = 0; i < 34; i++)
            send_beat(32'h100 + 32'(i), (i == 33), 3'd4);
        wait_done("t3_done");
        check("t3_xor_count", xa.size(), 32'd36);
        check_xor("t3_xor33", 33, 32'd33, 32'h0000_0121);
        check_xor("t3_xor34", 34, 32'd0, 32'h0000_0006);
        check_xor("t3_xor35", 35, 32'd33, 32'h8000_0000);
        check("t3_perms", nperm, 32'd2);
        check("t3_word0", at(od, 0), 32'h0300_0106);
        check("t3_word1", at(od, 1), 32'h0300_0101);
        check("t3_last1", at(ol, 1), 32'd1);

        // T4: SHAKE128, 50 words over two squeeze blocks
        start_hash(6'd42, DS_SHAKE, 8'd50);
        send_beat(32'h0, 1'b1, 3'd0);
        wait_done("t4_done");
        check_xor("t4_xor0", 0, 32'd0, 32'h0000_001F);
        check_xor("t4_xor1", 1, 32'd41, 32'h8000_0000);
        check("t4_perms", nperm, 32'd2);
        check("t4_words", od.size(), 32'd50);
        for (int unsigned i = 0; i < 50; i++) begin
            logic [31:0] e;
            if (i < 42) begin
                e = 32'h0100_0000 + 32'(i);
                if (i == 0)  e = 32'h0100_001F;
                if (i == 41) e = 32'h8100_0029;
            end else begin
                e = (i == 42) ? 32'h0300_001F : 32'h0300_0000;
            end
            check("t4_raddr", at(ra, i), (i < 42) ? 32'(i) : 32'(i - 42));
            check("t4_word", at(od, i), e);
            check("t4_last", at(ol, i), (i == 49) ? 32'd1 : 32'd0);
        end

        // T5: output backpressure
        out_ready = 1'b0;
        start_hash(6'd34, DS_SHA3, 8'd8);
        send_beat(32'h0, 1'b1, 3'd0);
        for (int k = 0; k < 200; k++) begin
            if (out_valid) break;
            tick();
        end
        check("t5_valid", 32'(out_valid), 32'd1);
        check("t5_data", out_data, 32'h0100_0006);
        for (int k = 0; k < 5; k++) begin
            tick();
            check("t5_hold_data", out_data, 32'h0100_0006);
            check("t5_hold_valid", 32'(out_valid), 32'd1);
            check("t5_no_reread", 32'(st_re), 32'd0);
        end
        out_ready = 1'b1;
        wait_done("t5_done");
        check("t5_reads", ra.size(), 32'd8);
        for (int unsigned i = 0; i < 8; i++)
            check("t5_word", at(od, i), t1_word(i));

        // Rate above the maximum clamps to 42
        start_hash(6'd50, DS_SHAKE, 8'd1);
        send_beat(32'h0, 1'b1, 3'd0);
        wait_done("clamp_done");
        check_xor("clamp_xor1", 1, 32'd41, 32'h8000_0000);

        // T6: reset during PERM, late perm_done afterwards
        start_hash(6'd34, DS_SHA3, 8'd8);
        send_beat(32'h0, 1'b1, 3'd0);
        for (int k = 0; k < 50; k++) begin
            if (perm_start) break;
            tick();
        end
        check("t6_in_perm", 32'(perm_start), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6_rst_ctrl", {23'h0, st_clr, st_xor, st_re, perm_start, out_valid, out_last,
                              busy, done, in_ready}, 32'h0);
        repeat (6) tick();
        check("t6_late_done_seen", ncore_done, 32'd1);
        check("t6_stay_idle", {29'h0, busy, out_valid, st_re}, 32'h0);
        start_hash(6'd34, DS_SHA3, 8'd8);
        send_beat(32'h1234_5678, 1'b1, 3'd0);
        wait_done("t6_done");
        check_t1("t6");

        check("exclusive_strobes", nexcl, 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
